// File: rtl/ibex_fetch_pkg.sv
// Shared types and helpers for the ring-buffer instruction fetch FIFO.
package ibex_fetch_pkg;

  // One fetched bus word together with its bus error flag.
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } fetch_entry_t;

  // A 16-bit parcel starts a compressed instruction unless its low two bits are 2'b11.
  function automatic logic is_compressed(logic [15:0] instr);
    logic unused_instr_hi;
    unused_instr_hi = ^instr[15:2];
    return (instr[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/ibex_fetch_aligner.sv
// Combinational output aligner: extracts the 16/32-bit instruction at the
// current halfword offset from the head word and the word following it.
module ibex_fetch_aligner
  import ibex_fetch_pkg::*;
(
  input  fetch_entry_t head_i,
  input  logic [15:0]  next_lo_i,
  input  logic         next_err_i,
  input  logic         word_valid_i,
  input  logic         pair_valid_i,
  input  logic         unaligned_i,
  output logic         valid_o,
  output logic [31:0]  rdata_o,
  output logic         err_o,
  output logic         err_plus2_o,
  output logic         compressed_o
);

  logic lo_compressed;
  logic hi_compressed;

  // Select the instruction window; an errored head word is never treated as compressed.
  always_comb begin
    lo_compressed = is_compressed(head_i.rdata[15:0]) & ~head_i.err;
    hi_compressed = is_compressed(head_i.rdata[31:16]) & ~head_i.err;
    valid_o       = word_valid_i;
    rdata_o       = head_i.rdata;
    err_o         = head_i.err;
    err_plus2_o   = 1'b0;
    compressed_o  = lo_compressed;
    if (unaligned_i) begin
      compressed_o = hi_compressed;
      valid_o      = hi_compressed ? word_valid_i : pair_valid_i;
      rdata_o      = {next_lo_i, head_i.rdata[31:16]};
      err_o        = head_i.err | (~hi_compressed & next_err_i);
      err_plus2_o  = next_err_i & ~head_i.err;
    end
  end

endmodule

// File: rtl/ibex_fetch_fifo_ring.sv
// Ring-buffer instruction fetch FIFO with bypass, occupancy count and a
// sticky overflow flag. Alignment of the output instruction is delegated
// to ibex_fetch_aligner.
module ibex_fetch_fifo_ring
  import ibex_fetch_pkg::*;
#(
  parameter int unsigned NUM_REQS = 2,
  parameter bit          ResetAll = 1'b0,
  localparam int unsigned DEPTH   = NUM_REQS + 1,
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  output logic [NUM_REQS-1:0] busy_o,
  output logic [CNT_W-1:0]    level_o,
  output logic                overflow_o,
  input  logic                in_valid_i,
  input  logic [31:0]         in_addr_i,
  input  logic [31:0]         in_rdata_i,
  input  logic                in_err_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [31:0]         out_addr_o,
  output logic [31:0]         out_rdata_o,
  output logic                out_err_o,
  output logic                out_err_plus2_o,
  output logic                out_is_compressed_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam ptr_t PTR_MAX  = ptr_t'(DEPTH - 1);
  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

  fetch_entry_t entry_q [DEPTH];
  fetch_entry_t entry_d [DEPTH];
  ptr_t         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_nxt;
  cnt_t         count_q, count_d;
  logic [31:1]  instr_addr_q, instr_addr_d;
  logic         overflow_q, overflow_d;

  fetch_entry_t in_entry, head;
  logic [15:0]  next_lo;
  logic         next_err;
  logic         word_valid, pair_valid, compressed;
  logic         accept, pop, push;
  logic         unused_addr_bit0;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == PTR_MAX) ? '0 : p + ptr_t'(1);
  endfunction

  assign in_entry         = '{err: in_err_i, rdata: in_rdata_i};
  assign rd_ptr_nxt       = ptr_inc(rd_ptr_q);
  assign unused_addr_bit0 = in_addr_i[0];

  // Head/next word selection with bypass of the incoming word when storage runs short.
  always_comb begin
    head       = (count_q != '0) ? entry_q[rd_ptr_q] : in_entry;
    next_lo    = (count_q >= cnt_t'(2)) ? entry_q[rd_ptr_nxt].rdata[15:0] : in_rdata_i[15:0];
    next_err   = (count_q >= cnt_t'(2)) ? entry_q[rd_ptr_nxt].err : in_err_i;
    word_valid = (count_q != '0) | in_valid_i;
    pair_valid = (count_q >= cnt_t'(2)) | ((count_q == cnt_t'(1)) & in_valid_i);
  end

  ibex_fetch_aligner u_aligner (
    .head_i       (head),
    .next_lo_i    (next_lo),
    .next_err_i   (next_err),
    .word_valid_i (word_valid),
    .pair_valid_i (pair_valid),
    .unaligned_i  (instr_addr_q[1]),
    .valid_o      (out_valid_o),
    .rdata_o      (out_rdata_o),
    .err_o        (out_err_o),
    .err_plus2_o  (out_err_plus2_o),
    .compressed_o (compressed)
  );

  // Push/pop bookkeeping, PC advance and overflow detection; clear_i wins over all of it.
  always_comb begin
    accept       = out_valid_o & out_ready_i;
    pop          = accept & (instr_addr_q[1] | ~compressed);
    push         = in_valid_i & ~clear_i & ((count_q != CNT_FULL) | pop);
    entry_d      = entry_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    instr_addr_d = instr_addr_q;
    overflow_d   = overflow_q;
    if (clear_i) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      overflow_d   = 1'b0;
      instr_addr_d = in_addr_i[31:1];
    end else begin
      if (push) begin
        entry_d[wr_ptr_q] = in_entry;
        wr_ptr_d          = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_nxt;
      end
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
      if (in_valid_i & (count_q == CNT_FULL) & ~pop) begin
        overflow_d = 1'b1;
      end
      if (accept) begin
        instr_addr_d = instr_addr_q + (compressed ? 31'd1 : 31'd2);
      end
    end
  end

  // Control state, always reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Word storage and PC; reset only when ResetAll is set.
  always_ff @(posedge clk_i) begin
    if (ResetAll && rst_i) begin
      entry_q      <= '{default: '0};
      instr_addr_q <= '0;
    end else begin
      entry_q      <= entry_d;
      instr_addr_q <= instr_addr_d;
    end
  end

  // Thermometer fill indication: bit k set once k+2 words are held.
  always_comb begin
    busy_o = '0;
    for (int k = 0; k < int'(NUM_REQS); k++) begin
      busy_o[k] = (int'(count_q) >= k + 2);
    end
  end

  assign level_o             = count_q;
  assign overflow_o          = overflow_q;
  assign out_addr_o          = {instr_addr_q, 1'b0};
  assign out_is_compressed_o = compressed;

endmodule

// File: tb/tb_ibex_fetch_fifo_ring.sv
`timescale 1ns/1ps
module tb_ibex_fetch_fifo_ring;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clear, in_valid, in_err, out_ready;
  logic [31:0] in_addr, in_rdata;

  logic [1:0]  busy2;
  logic [1:0]  level2;
  logic        ovf2, ov2, oerr2, op2_2, oc2;
  logic [31:0] oaddr2, ordata2;
  logic [3:0]  busy4;
  logic [2:0]  level4;
  logic        ovf4, ov4, oerr4, op2_4, oc4;
  logic [31:0] oaddr4, ordata4;

  ibex_fetch_fifo_ring #(.NUM_REQS(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy2), .level_o(level2),
    .overflow_o(ovf2), .in_valid_i(in_valid), .in_addr_i(in_addr), .in_rdata_i(in_rdata),
    .in_err_i(in_err), .out_valid_o(ov2), .out_ready_i(out_ready), .out_addr_o(oaddr2),
    .out_rdata_o(ordata2), .out_err_o(oerr2), .out_err_plus2_o(op2_2),
    .out_is_compressed_o(oc2)
  );

  ibex_fetch_fifo_ring #(.NUM_REQS(4), .ResetAll(1'b1)) dut4 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy4), .level_o(level4),
    .overflow_o(ovf4), .in_valid_i(in_valid), .in_addr_i(in_addr), .in_rdata_i(in_rdata),
    .in_err_i(in_err), .out_valid_o(ov4), .out_ready_i(out_ready), .out_addr_o(oaddr4),
    .out_rdata_o(ordata4), .out_err_o(oerr4), .out_err_plus2_o(op2_4),
    .out_is_compressed_o(oc4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // Reference model: a plain FIFO of {err, rdata} words per instance, shifted on pop.
  localparam int MAXD = 8;
  logic [32:0] mq [2][MAXD];
  int          mcnt   [2] = '{0, 0};
  logic [31:0] maddr  [2] = '{32'h0, 32'h0};
  bit          mknown [2] = '{1'b0, 1'b1};
  bit          movf   [2] = '{1'b0, 1'b0};
  bit          cmp_en = 1'b0;

  function automatic int depth(input int i);
    return (i == 0) ? 3 : 5;
  endfunction

  function automatic logic [31:0] exp_busy(input int cnt, input int nreq);
    logic [31:0] b = '0;
    for (int k = 0; k < nreq; k++) if (cnt >= k + 2) b[k] = 1'b1;
    return b;
  endfunction

  // The instruction is a run of len halfwords starting at halfword offset off
  // within the stream of available words (stored words followed by the input word).
  task automatic model_out(input int i, output bit v, output logic [31:0] rd, output bit er,
                           output bit p2, output bit cp, output int len, output int off);
    logic [32:0] w0, w1;
    logic [15:0] hw [4];
    int words;
    words = mcnt[i] + (in_valid ? 1 : 0);
    w0 = (mcnt[i] >= 1) ? mq[i][0] : {in_err, in_rdata};
    w1 = (mcnt[i] >= 2) ? mq[i][1] : {in_err, in_rdata};
    hw[0] = w0[15:0]; hw[1] = w0[31:16]; hw[2] = w1[15:0]; hw[3] = w1[31:16];
    off = maddr[i][1] ? 1 : 0;
    cp  = (hw[off][1:0] != 2'b11) && !w0[32];
    len = cp ? 1 : 2;
    v   = (off + len) <= 2 * words;
    rd  = {hw[off + 1], hw[off]};
    er  = w0[32] | ((off + len > 2) ? w1[32] : 1'b0);
    p2  = (off == 1) ? (w1[32] & ~w0[32]) : 1'b0;
  endtask

  task automatic model_update(input int i);
    bit v, er, p2, cp, took_in;
    logic [31:0] rd;
    int len, off;
    if (rst) begin
      mcnt[i] = 0; movf[i] = 1'b0; mknown[i] = (i == 1); maddr[i] = '0;
      return;
    end
    if (clear) begin
      mcnt[i] = 0; movf[i] = 1'b0; mknown[i] = 1'b1; maddr[i] = {in_addr[31:1], 1'b0};
      return;
    end
    model_out(i, v, rd, er, p2, cp, len, off);
    took_in = 1'b0;
    if (v && out_ready && mknown[i]) begin
      maddr[i] = maddr[i] + 32'(2 * len);
      if (off + len >= 2) begin
        if (mcnt[i] > 0) begin
          for (int k = 0; k < MAXD - 1; k++) mq[i][k] = mq[i][k + 1];
          mcnt[i]--;
        end else begin
          took_in = 1'b1;
        end
      end
    end
    if (in_valid && !took_in) begin
      if (mcnt[i] < depth(i)) begin
        mq[i][mcnt[i]] = {in_err, in_rdata};
        mcnt[i]++;
      end else begin
        movf[i] = 1'b1;
      end
    end
  endtask

  task automatic compare_dut(input int i);
    bit v, er, p2, cp;
    logic [31:0] rd;
    int len, off;
    logic [31:0] a_lvl, a_busy, a_addr, a_rd;
    logic a_v, a_ovf, a_er, a_p2, a_cp;
    string p;
    p = (i == 0) ? "n2" : "n4";
    if (i == 0) begin
      a_lvl = 32'(level2); a_busy = 32'(busy2); a_addr = oaddr2; a_rd = ordata2;
      a_v = ov2; a_ovf = ovf2; a_er = oerr2; a_p2 = op2_2; a_cp = oc2;
    end else begin
      a_lvl = 32'(level4); a_busy = 32'(busy4); a_addr = oaddr4; a_rd = ordata4;
      a_v = ov4; a_ovf = ovf4; a_er = oerr4; a_p2 = op2_4; a_cp = oc4;
    end
    model_out(i, v, rd, er, p2, cp, len, off);
    chk({p, ".level"}, a_lvl, 32'(mcnt[i]));
    chk({p, ".busy"}, a_busy, exp_busy(mcnt[i], depth(i) - 1));
    chk({p, ".overflow"}, 32'(a_ovf), 32'(movf[i]));
    if (mknown[i]) begin
      chk({p, ".addr"}, a_addr, maddr[i]);
      chk({p, ".valid"}, 32'(a_v), 32'(v));
      if (v) begin
        chk({p, ".rdata"}, a_rd, rd);
        chk({p, ".err"}, 32'(a_er), 32'(er));
        chk({p, ".err_plus2"}, 32'(a_p2), 32'(p2));
        chk({p, ".compressed"}, 32'(a_cp), 32'(cp));
      end
    end
  endtask

  // Every cycle: check both instances against the model, then advance the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) compare_dut(i);
      for (int i = 0; i < 2; i++) model_update(i);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_err = 1'b0; out_ready = 1'b0;
    in_addr = '0; in_rdata = '0;
    step();
    rst = 1'b0; cmp_en = 1'b1;
    #2;
    chk("rst.level", 32'(level2), 0);
    chk("rst.busy", 32'(busy2), 0);
    chk("rst.overflow", 32'(ovf2), 0);
    chk("rst.valid_idle", 32'(ov4), 0);
    chk("rst.addr_resetall", oaddr4, 32'h0);
    in_valid = 1'b1; in_rdata = 32'h00000013;
    #1;
    chk("rst.valid_follows_in", 32'(ov4), 1);

    // Aligned bypass
    step(); in_valid = 1'b0; clear = 1'b1; in_addr = 32'h100;
    step(); clear = 1'b0; in_valid = 1'b1; in_rdata = 32'h00000013; out_ready = 1'b1;
    #2;
    chk("byp.addr", oaddr2, 32'h100);
    chk("byp.rdata", ordata2, 32'h00000013);
    chk("byp.valid", 32'(ov2), 1);
    step(); in_valid = 1'b0; out_ready = 1'b0;
    #2;
    chk("byp.addr_next", oaddr2, 32'h104);
    chk("byp.level", 32'(level2), 0);

    // Unaligned compressed
    step(); clear = 1'b1; in_addr = 32'h102;
    step(); clear = 1'b0; in_valid = 1'b1; in_rdata = 32'h45014501;
    step(); in_rdata = 32'h00000093;
    #2;
    chk("c16.valid", 32'(ov2), 1);
    chk("c16.addr", oaddr2, 32'h102);
    chk("c16.rdata", ordata2, 32'h00934501);
    chk("c16.compressed", 32'(oc2), 1);
    out_ready = 1'b1;
    step(); in_valid = 1'b0; out_ready = 1'b0;
    #2;
    chk("c16.level_after", 32'(level2), 1);
    chk("c16.addr_after", oaddr2, 32'h104);
    chk("c16.rdata_after", ordata2, 32'h00000093);

    // Unaligned: upper half 0xAAAA is itself a compressed parcel
    step(); clear = 1'b1; in_addr = 32'h102;
    step(); clear = 1'b0; in_valid = 1'b1; in_rdata = 32'hAAAA0513;
    #2;
    chk("u1.valid", 32'(ov2), 1);
    chk("u1.rdata_bypass", ordata2, 32'h0513AAAA);
    step(); in_rdata = 32'hBBBB0000;
    #2;
    chk("u1.rdata", ordata2, 32'h0000AAAA);

    // Unaligned 32-bit instruction waits for the second word
    step(); clear = 1'b1; in_valid = 1'b0;
    step(); clear = 1'b0; in_valid = 1'b1; in_rdata = 32'hAAAB0513;
    #2;
    chk("u32.wait", 32'(ov2), 0);
    step(); in_rdata = 32'hBBBB0000;
    #2;
    chk("u32.valid", 32'(ov2), 1);
    chk("u32.rdata", ordata2, 32'h0000AAAB);
    chk("u32.compressed", 32'(oc2), 0);
    chk("u32.err", 32'(oerr2), 0);

    // Error in the second half of an unaligned 32-bit instruction
    step(); clear = 1'b1; in_valid = 1'b0;
    step(); clear = 1'b0; in_valid = 1'b1; in_rdata = 32'hAAAB0513;
    step(); in_rdata = 32'hBBBB0000; in_err = 1'b1;
    #2;
    chk("u32e.err", 32'(oerr2), 1);
    chk("u32e.err_plus2", 32'(op2_2), 1);

    // Fill, overflow, push+pop at full
    step(); in_err = 1'b0; in_valid = 1'b0; clear = 1'b1; in_addr = 32'h0;
    step(); clear = 1'b0; in_valid = 1'b1; in_rdata = 32'h00000013;
    step(); in_rdata = 32'h00100093;
    step(); in_rdata = 32'h00200113;
    step(); in_valid = 1'b0;
    #2;
    chk("full.level", 32'(level2), 3);
    chk("full.busy", 32'(busy2), 32'h3);
    chk("full.busy4", 32'(busy4), 32'h3);
    step(); in_valid = 1'b1; in_rdata = 32'h00300193;
    step(); in_valid = 1'b0;
    #2;
    chk("ovf.flag", 32'(ovf2), 1);
    chk("ovf.level", 32'(level2), 3);
    chk("ovf.level4", 32'(level4), 4);
    step(); clear = 1'b1;
    step(); clear = 1'b0; in_valid = 1'b1; in_rdata = 32'h00000013;
    step(); in_rdata = 32'h00100093;
    step(); in_rdata = 32'h00200113;
    step(); in_rdata = 32'h00300193; out_ready = 1'b1;
    step(); in_valid = 1'b0; out_ready = 1'b0;
    #2;
    chk("pp.level", 32'(level2), 3);
    chk("pp.overflow", 32'(ovf2), 0);
    chk("pp.head", ordata2, 32'h00100093);

    // Random streaming with occasional clears and one mid-stream reset
    step(); clear = 1'b1; in_addr = 32'h1000;
    for (int c = 0; c < 600; c++) begin
      step();
      rst       = (c == 300);
      clear     = (c == 301) || ($urandom_range(0, 99) == 0);
      in_addr   = $urandom;
      in_valid  = ($urandom_range(0, 2) != 0);
      in_rdata  = $urandom;
      in_err    = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (c == 301) begin
        #2;
        chk("midrst.level", 32'(level2), 0);
        chk("midrst.level4", 32'(level4), 0);
      end
    end
    step();
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
